// File: rtl/fpu_stream_pkg.sv
// fpu_stream_pkg: state encoding and chunk-count helper shared by the FPU stream controller.
package fpu_stream_pkg;
    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, START, WAIT, SEND} state_e;
    function automatic int chunks(input int data_w, input int bus_w);
        return (data_w + bus_w - 1) / bus_w;
    endfunction
endpackage

// File: rtl/stream_shifter.sv
// stream_shifter: LSB-first chunk shift register with beat counter, used for both operand assembly and result serialisation.
module stream_shifter
    import fpu_stream_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int BUS_W  = 10,
    parameter int OUT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] load_data_i,
    input  logic              shift_i,
    input  logic [BUS_W-1:0]  shift_data_i,
    output logic [OUT_W-1:0]  next_o,
    output logic              last_o
);
    localparam int CHUNKS = chunks(DATA_W, BUS_W);
    localparam int SW = CHUNKS * BUS_W;
    localparam int CW = CHUNKS > 1 ? $clog2(CHUNKS) : 1;
    logic [SW-1:0] sr_q, sr_d;
    logic [SW+BUS_W-1:0] cat;
    logic [CW-1:0] cnt_q, cnt_d;
    assign last_o = cnt_q == CW'(CHUNKS - 1);
    assign next_o = sr_d[OUT_W-1:0];
    // New chunks enter at the top so the first beat ends up least significant.
    always_comb begin
        cat = {shift_data_i, sr_q};
        sr_d = load_i ? SW'(load_data_i) : shift_i ? cat[SW+BUS_W-1:BUS_W] : sr_q;
        cnt_d = (load_i || clear_i) ? '0 : shift_i ? (last_o ? '0 : cnt_q + 1'b1) : cnt_q;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            sr_q <= '0;
            cnt_q <= '0;
        end else begin
            sr_q <= sr_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/fpu_stream_ctrl.sv
// fpu_stream_ctrl: loads opcode and operands from narrow input beats, launches the FPU, and streams the result
// (or an all-ones timeout result) back out in narrow beats.
module fpu_stream_ctrl
    import fpu_stream_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int BUS_W   = 10,
    parameter int OP_W    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [BUS_W-1:0]  in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] calc_a,
    output logic [DATA_W-1:0] calc_b,
    output logic [OP_W-1:0]   calc_op,
    output logic              calc_start,
    input  logic              calc_done,
    input  logic [DATA_W-1:0] calc_result,
    output logic [BUS_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              err,
    output logic              busy
);
    localparam int TW = $clog2(TIMEOUT + 1);
    state_e state_q;
    logic [TW-1:0] wait_q;
    logic [DATA_W-1:0] a_q, b_q, in_next;
    logic [OP_W-1:0] op_q;
    logic [BUS_W-1:0] out_q, out_next;
    logic err_q, loading, in_xfer, out_xfer, done_hit, time_hit, capture, in_last, out_last;
    assign loading = state_q == LOAD_A || state_q == LOAD_B;
    assign in_ready = !reset && (state_q == IDLE || loading);
    assign in_xfer = in_valid && in_ready;
    assign out_valid = state_q == SEND;
    assign out_xfer = out_valid && out_ready;
    assign done_hit = state_q == WAIT && calc_done;
    assign time_hit = state_q == WAIT && !calc_done && wait_q == TW'(TIMEOUT - 1);
    assign capture = done_hit || time_hit;
    assign calc_start = state_q == START;
    assign busy = state_q != IDLE;
    assign {calc_a, calc_b, calc_op, out_data, err} = {a_q, b_q, op_q, out_q, err_q};
    stream_shifter #(.DATA_W(DATA_W), .BUS_W(BUS_W), .OUT_W(DATA_W)) u_in (
        .clock(clock), .reset(reset), .clear_i(state_q == IDLE), .load_i(1'b0), .load_data_i('0),
        .shift_i(in_xfer && loading), .shift_data_i(in_data), .next_o(in_next), .last_o(in_last)
    );
    stream_shifter #(.DATA_W(DATA_W), .BUS_W(BUS_W), .OUT_W(BUS_W)) u_out (
        .clock(clock), .reset(reset), .clear_i(1'b0), .load_i(capture),
        .load_data_i(done_hit ? calc_result : '1), .shift_i(out_xfer), .shift_data_i('0),
        .next_o(out_next), .last_o(out_last)
    );
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            wait_q <= '0;
            a_q <= '0;
            b_q <= '0;
            op_q <= '0;
            out_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (capture || out_xfer) out_q <= out_next;
            if (state_q == IDLE && in_xfer) op_q <= in_data[OP_W-1:0];
            if (state_q == LOAD_A && in_xfer && in_last) a_q <= in_next;
            if (state_q == LOAD_B && in_xfer && in_last) b_q <= in_next;
            case (state_q)
                IDLE:    if (in_xfer) state_q <= LOAD_A;
                LOAD_A:  if (in_xfer && in_last) state_q <= LOAD_B;
                LOAD_B:  if (in_xfer && in_last) state_q <= START;
                START: begin
                    wait_q <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    wait_q <= wait_q + 1'b1;
                    if (capture) begin
                        err_q <= time_hit;
                        state_q <= SEND;
                    end
                end
                SEND: if (out_xfer && out_last) begin
                    err_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fpu_stream_ctrl.sv
// tb_fpu_stream_ctrl: scenario tasks plus randomized transactions checked against a chunk-arithmetic reference model.
module tb_fpu_stream_ctrl;
    localparam int TO = 4;
    logic clock = 1'b0, reset = 1'b1;
    logic [9:0] in_data = '0, out_data;
    logic in_valid = 1'b0, in_ready, calc_start, calc_done = 1'b0, out_valid, out_ready = 1'b0, err, busy;
    logic [15:0] calc_a, calc_b, calc_result = '0;
    logic [3:0] calc_op;
    logic [7:0] in_data_w = '0, out_data_w;
    logic in_valid_w = 1'b0, in_ready_w, calc_start_w, calc_done_w = 1'b0, out_valid_w, out_ready_w = 1'b0, err_w, busy_w;
    logic [31:0] calc_a_w, calc_b_w, calc_result_w = '0;
    logic [3:0] calc_op_w;
    int n_chk = 0, n_fail = 0;
    logic [15:0] o_a, o_b, o_a_end, o_b_end;
    logic [3:0] o_op, o_op_end;
    logic [9:0] o_beat [2];
    logic o_err [2];
    logic o_lat, o_err_after, o_busy_after, o_timeout;
    int o_starts, o_wait, o_leak, o_unstable;

    always #5 clock = ~clock;

    fpu_stream_ctrl #(.DATA_W(16), .BUS_W(10), .OP_W(4), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .calc_a(calc_a), .calc_b(calc_b), .calc_op(calc_op), .calc_start(calc_start),
        .calc_done(calc_done), .calc_result(calc_result), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .err(err), .busy(busy)
    );
    fpu_stream_ctrl #(.DATA_W(32), .BUS_W(8), .OP_W(4), .TIMEOUT(8)) dut_w (
        .clock(clock), .reset(reset), .in_data(in_data_w), .in_valid(in_valid_w), .in_ready(in_ready_w),
        .calc_a(calc_a_w), .calc_b(calc_b_w), .calc_op(calc_op_w), .calc_start(calc_start_w),
        .calc_done(calc_done_w), .calc_result(calc_result_w), .out_data(out_data_w), .out_valid(out_valid_w),
        .out_ready(out_ready_w), .err(err_w), .busy(busy_w)
    );

    // Drives one full transaction on the 16/10 instance and records what was observed; callers compare.
    task automatic run_txn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input logic [15:0] res,
                           input int dly, input bit gap, input bit junk, input int stall_n);
        logic [9:0] bt [5];
        logic [9:0] prev = '0;
        int idx = 0, cyc = 0, nb = 0, stall = stall_n;
        bit acc, have_prev = 0;
        bt[0] = {junk ? 6'($urandom) : 6'd0, op};
        bt[1] = a[9:0];
        bt[2] = {junk ? 4'($urandom) : 4'd0, a[15:10]};
        bt[3] = b[9:0];
        bt[4] = {junk ? 4'($urandom) : 4'd0, b[15:10]};
        o_starts = 0; o_wait = 0; o_leak = 0; o_unstable = 0;
        while (idx < 5 && cyc < 200) begin
            if (calc_start) o_starts++;
            in_valid = gap ? (cyc % 2 == 1) : 1'b1;
            in_data = bt[idx];
            calc_done = junk ? 1'($urandom) : 1'b0;
            calc_result = 16'($urandom);
            acc = in_valid && in_ready;
            @(negedge clock); cyc++;
            if (acc) idx++;
        end
        o_lat = calc_start; o_a = calc_a; o_b = calc_b; o_op = calc_op;
        in_valid = 1'b1;
        while (nb < 2 && cyc < 400) begin
            in_data = 10'($urandom);
            if (calc_start) o_starts++;
            if (in_ready) o_leak++;
            if (busy && !calc_start && !out_valid) begin
                calc_done = (o_wait == dly);
                calc_result = res;
                o_wait++;
            end else begin
                calc_done = junk ? 1'($urandom) : 1'b0;
                calc_result = 16'($urandom);
            end
            out_ready = junk ? 1'($urandom) : 1'b0;
            if (out_valid) begin
                if (have_prev && out_data !== prev) o_unstable++;
                out_ready = !(nb == 1 && stall > 0);
                if (out_ready) begin
                    o_beat[nb] = out_data; o_err[nb] = err; nb++; have_prev = 0;
                end else begin
                    prev = out_data; have_prev = 1; stall--;
                end
            end
            @(negedge clock); cyc++;
        end
        in_valid = 1'b0; calc_done = 1'b0; out_ready = 1'b0;
        o_timeout = idx < 5 || nb < 2;
        o_err_after = err; o_busy_after = busy | out_valid;
        o_a_end = calc_a; o_b_end = calc_b; o_op_end = calc_op;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready_during got %b want 0", in_ready); end
        reset = 1'b0; #1;
        n_chk++; if ({in_ready, in_ready_w} !== 2'b11) begin n_fail++; $display("FAIL reset_in_ready_after got %b%b want 11", in_ready, in_ready_w); end
        n_chk++;
        if ({calc_a, calc_b, calc_op, calc_start, out_valid, out_data, err, busy} !== '0) begin
            n_fail++; $display("FAIL reset_outputs got a=%h b=%h op=%h st=%b ov=%b od=%h err=%b busy=%b want all 0", calc_a, calc_b, calc_op, calc_start, out_valid, out_data, err, busy);
        end
        n_chk++;
        if ({calc_a_w, calc_b_w, calc_op_w, calc_start_w, out_valid_w, out_data_w, err_w, busy_w} !== '0) begin
            n_fail++; $display("FAIL reset_outputs_w got a=%h b=%h od=%h busy=%b want all 0", calc_a_w, calc_b_w, out_data_w, busy_w);
        end
        @(negedge clock);
    endtask

    task automatic test_basic();
        run_txn(4'h1, 16'h3C00, 16'h4000, 16'h4200, 0, 1'b0, 1'b0, 0);
        n_chk++; if ({o_op, o_a, o_b} !== {4'h1, 16'h3C00, 16'h4000}) begin n_fail++; $display("FAIL basic_operands got %h/%h/%h want 1/3c00/4000", o_op, o_a, o_b); end
        n_chk++; if ({o_beat[0], o_beat[1]} !== {10'h200, 10'h010}) begin n_fail++; $display("FAIL basic_beats got %h,%h want 200,010", o_beat[0], o_beat[1]); end
        n_chk++; if ({o_err[0], o_err[1], o_err_after} !== 3'b000) begin n_fail++; $display("FAIL basic_err got %b%b%b want 000", o_err[0], o_err[1], o_err_after); end
        n_chk++;
        if (o_lat !== 1'b1 || o_starts != 1 || o_wait != 1 || o_leak != 0 || o_timeout !== 1'b0 || o_busy_after !== 1'b0) begin
            n_fail++; $display("FAIL basic_protocol got lat=%b starts=%0d wait=%0d leak=%0d to=%b busy=%b want 1/1/1/0/0/0", o_lat, o_starts, o_wait, o_leak, o_timeout, o_busy_after);
        end
    endtask

    task automatic test_back_pressure();
        run_txn(4'h1, 16'h3C00, 16'h4000, 16'h4200, 0, 1'b1, 1'b0, 3);
        n_chk++; if ({o_op, o_a, o_b} !== {4'h1, 16'h3C00, 16'h4000}) begin n_fail++; $display("FAIL bp_operands got %h/%h/%h want 1/3c00/4000", o_op, o_a, o_b); end
        n_chk++; if ({o_beat[0], o_beat[1]} !== {10'h200, 10'h010}) begin n_fail++; $display("FAIL bp_beats got %h,%h want 200,010", o_beat[0], o_beat[1]); end
        n_chk++; if (o_unstable != 0 || o_starts != 1 || o_timeout !== 1'b0) begin n_fail++; $display("FAIL bp_stall got unstable=%0d starts=%0d to=%b want 0/1/0", o_unstable, o_starts, o_timeout); end
    endtask

    task automatic test_timeout();
        run_txn(4'h7, 16'h1234, 16'hABCD, 16'h5555, 99, 1'b0, 1'b0, 0);
        n_chk++; if (o_wait != TO || o_timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_wait got %0d cycles to=%b want %0d", o_wait, o_timeout, TO); end
        n_chk++; if ({o_beat[0], o_beat[1]} !== {10'h3FF, 10'h03F}) begin n_fail++; $display("FAIL timeout_beats got %h,%h want 3ff,03f", o_beat[0], o_beat[1]); end
        n_chk++; if ({o_err[0], o_err[1], o_err_after} !== 3'b110) begin n_fail++; $display("FAIL timeout_err got %b%b%b want 110", o_err[0], o_err[1], o_err_after); end
    endtask

    task automatic test_reset_mid_load();
        logic [15:0] a = 16'($urandom), b = 16'($urandom), r = 16'($urandom);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 10'($urandom) | 10'h001;
            @(negedge clock);
        end
        in_valid = 1'b0; reset = 1'b1;
        @(negedge clock);
        reset = 1'b0; #1;
        n_chk++;
        if ({busy, in_ready, calc_a, calc_op} !== {1'b0, 1'b1, 16'h0, 4'h0}) begin
            n_fail++; $display("FAIL midreset_state got busy=%b rdy=%b a=%h op=%h want 0/1/0000/0", busy, in_ready, calc_a, calc_op);
        end
        run_txn(4'hA, a, b, r, 1, 1'b0, 1'b1, 0);
        n_chk++; if ({o_op, o_a, o_b} !== {4'hA, a, b}) begin n_fail++; $display("FAIL midreset_operands got %h/%h/%h want a/%h/%h", o_op, o_a, o_b, a, b); end
        n_chk++; if ({o_beat[0], o_beat[1]} !== {10'(r % 1024), 10'(r / 1024)}) begin n_fail++; $display("FAIL midreset_beats got %h,%h want %h,%h", o_beat[0], o_beat[1], r % 1024, r / 1024); end
    endtask

    task automatic test_random();
        for (int t = 0; t < 25; t++) begin
            logic [3:0] op = 4'($urandom);
            logic [15:0] a = 16'($urandom), b = 16'($urandom), res = 16'($urandom), r;
            int dly = $urandom_range(0, 6);
            int ew = dly < TO ? dly + 1 : TO;
            bit to = dly >= TO;
            r = to ? 16'hFFFF : res;
            run_txn(op, a, b, res, dly, 1'($urandom), 1'b1, $urandom_range(0, 3));
            n_chk++;
            if ({o_op, o_a, o_b, o_op_end, o_a_end, o_b_end} !== {op, a, b, op, a, b}) begin
                n_fail++; $display("FAIL rand%0d_operands got %h/%h/%h end %h/%h/%h want %h/%h/%h", t, o_op, o_a, o_b, o_op_end, o_a_end, o_b_end, op, a, b);
            end
            n_chk++;
            if ({o_beat[0], o_beat[1], o_err[0], o_err[1]} !== {10'(r % 1024), 10'(r / 1024), to, to}) begin
                n_fail++; $display("FAIL rand%0d_result got %h,%h err %b%b want %h,%h err %b", t, o_beat[0], o_beat[1], o_err[0], o_err[1], r % 1024, r / 1024, to);
            end
            n_chk++;
            if (o_lat !== 1'b1 || o_starts != 1 || o_wait != ew || o_leak != 0 || o_unstable != 0 || o_timeout !== 1'b0 || o_err_after !== 1'b0 || o_busy_after !== 1'b0) begin
                n_fail++; $display("FAIL rand%0d_protocol got lat=%b starts=%0d wait=%0d leak=%0d unst=%0d to=%b err=%b busy=%b want 1/1/%0d/0/0/0/0/0", t, o_lat, o_starts, o_wait, o_leak, o_unstable, o_timeout, o_err_after, o_busy_after, ew);
            end
        end
    endtask

    task automatic test_width();
        logic [31:0] a = 32'hDEADBEEF, b = $urandom, r = 32'h12345678;
        logic [7:0] bt [9];
        logic [7:0] got [4];
        int nb = 0, cyc = 0;
        bt[0] = 8'h03;
        for (int i = 0; i < 4; i++) begin
            bt[1 + i] = 8'((a >> (8 * i)) % 256);
            bt[5 + i] = 8'((b >> (8 * i)) % 256);
        end
        in_valid_w = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_data_w = bt[i];
            @(negedge clock);
        end
        in_valid_w = 1'b0;
        n_chk++;
        if ({calc_a_w, calc_b_w, calc_op_w, calc_start_w} !== {a, b, 4'h3, 1'b1}) begin
            n_fail++; $display("FAIL width_operands got %h/%h/%h st=%b want deadbeef/%h/3 st=1", calc_a_w, calc_b_w, calc_op_w, calc_start_w, b);
        end
        @(negedge clock);
        calc_done_w = 1'b1; calc_result_w = r;
        @(negedge clock);
        calc_done_w = 1'b0; out_ready_w = 1'b1;
        while (nb < 4 && cyc < 50) begin
            if (out_valid_w) begin got[nb] = out_data_w; nb++; end
            @(negedge clock); cyc++;
        end
        out_ready_w = 1'b0;
        n_chk++;
        if (nb != 4 || {got[0], got[1], got[2], got[3]} !== {8'(r % 256), 8'((r >> 8) % 256), 8'((r >> 16) % 256), 8'(r >> 24)}) begin
            n_fail++; $display("FAIL width_beats got %0d beats %h %h %h %h want 78 56 34 12", nb, got[0], got[1], got[2], got[3]);
        end
        n_chk++; if ({busy_w, out_valid_w, err_w} !== 3'b000) begin n_fail++; $display("FAIL width_idle got busy=%b ov=%b err=%b want 000", busy_w, out_valid_w, err_w); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_pressure();
        test_timeout();
        test_reset_mid_load();
        test_random();
        test_width();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
